// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W        = 4;
    localparam int DIGITS_DEFAULT = 8;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    // Largest value representable in 'digits' BCD digits: 10^digits - 1.
    function automatic longint unsigned max_bcd_val(input int digits);
        longint unsigned v;
        v = 64'd1;
        for (int unsigned i = 0; i < 32'(digits); i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] q_o
);

    always_comb begin
        q_o = d_i;
        if (d_i >= DIGIT_W'(5)) begin
            q_o = d_i + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional signed input via macro BIN2BCD_SIGN_EN (two's complement, magnitude + neg flag).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 26,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      neg
);

    localparam int WORK_W = DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);

`ifdef BIN2BCD_SIGN_EN
    if ((64'd1 << (BIN_W - 1)) > max_bcd_val(DIGITS)) begin : g_range_err
        $error("bin2bcd_seq: 2^(BIN_W-1) exceeds 10^DIGITS-1");
    end
`else
    if (((64'd1 << BIN_W) - 64'd1) > max_bcd_val(DIGITS)) begin : g_range_err
        $error("bin2bcd_seq: 2^BIN_W-1 exceeds 10^DIGITS-1");
    end
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [WORK_W-1:0]   work_q,  work_d;
    logic [WORK_W-1:0]   bcd_q,   bcd_d;
    logic                done_q,  done_d;
    logic [WORK_W-1:0]   work_adj;
    logic [WORK_W-1:0]   work_shl;
    logic [BIN_W-1:0]    mag;

`ifdef BIN2BCD_SIGN_EN
    logic sign_q, sign_d;
    logic neg_q,  neg_d;

    // Unsigned BIN_W-bit negate, so the most negative input yields 2^(BIN_W-1).
    assign mag = bin[BIN_W-1] ? -bin : bin;
    assign neg = neg_q;
`else
    assign mag = bin;
    assign neg = 1'b0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .d_i (work_q  [g*DIGIT_W +: DIGIT_W]),
            .q_o (work_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign work_shl = {work_adj[WORK_W-2:0], shift_q[BIN_W-1]};

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef BIN2BCD_SIGN_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    shift_d = mag;
                    work_d  = '0;
                    cnt_d   = '0;
`ifdef BIN2BCD_SIGN_EN
                    sign_d  = bin[BIN_W-1];
`endif
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                work_d  = work_shl;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_IDLE;
                    bcd_d   = work_shl;
                    done_d  = 1'b1;
`ifdef BIN2BCD_SIGN_EN
                    neg_d   = sign_q;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
`ifdef BIN2BCD_SIGN_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
`ifdef BIN2BCD_SIGN_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expectations queued at accepted starts, checked on done.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 26;
    localparam int DIGITS = 8;

    typedef struct {
        logic [31:0] bcd;
        logic        neg;
        int          acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BIN_W-1:0]  bin;
    logic              busy;
    logic              done;
    logic [31:0]       bcd;
    logic              neg;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_at_edge = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] hold_bcd = '0;
    logic        hold_neg = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg)
    );

    function automatic logic [31:0] to_bcd(input logic [BIN_W-1:0] v);
        logic [31:0]      r;
        logic [BIN_W-1:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [BIN_W-1:0] v, input int acc);
        exp_t             x;
        logic [BIN_W-1:0] m;
        m     = v;
        x.neg = 1'b0;
`ifdef BIN2BCD_SIGN_EN
        if (v[BIN_W-1]) begin
            m     = ~v + 1'b1;
            x.neg = 1'b1;
        end
`endif
        x.bcd = to_bcd(m);
        x.acc = acc;
        return x;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_at_edge = rst;
        end
    end

    // Monitor: reset values, scoreboard on done, hold between done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                checks++;
                assert ({busy, done, neg, bcd} === 35'd0) else begin
                    errors++;
                    $error("FAIL reset_state: busy=%b done=%b neg=%b bcd=%h expected 0 0 0 00000000",
                           busy, done, neg, bcd);
                end
                hold_bcd = '0;
                hold_neg = 1'b0;
            end else if (done === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_done: done=1 at cycle %0d with no conversion pending", cyc);
                end
                checks++;
                assert (prev_done !== 1'b1) else begin
                    errors++;
                    $error("FAIL done_width: done high 2 cycles, expected 1-cycle pulse");
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (bcd === e.bcd) else begin
                        errors++;
                        $error("FAIL bcd: got %h expected %h", bcd, e.bcd);
                    end
                    checks++;
                    assert (neg === e.neg) else begin
                        errors++;
                        $error("FAIL neg: got %b expected %b", neg, e.neg);
                    end
                    checks++;
                    assert (cyc === e.acc + BIN_W) else begin
                        errors++;
                        $error("FAIL latency: done at edge %0d expected %0d", cyc, e.acc + BIN_W);
                    end
                    hold_bcd = e.bcd;
                    hold_neg = e.neg;
                end
            end else if (cyc > 0) begin
                checks++;
                assert ({neg, bcd} === {hold_neg, hold_bcd}) else begin
                    errors++;
                    $error("FAIL hold: bcd=%h neg=%b expected %h %b", bcd, neg, hold_bcd, hold_neg);
                end
            end
            prev_done = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with busy=0: the next posedge accepts.
    task automatic kick(input logic [BIN_W-1:0] v);
        bin   = v;
        start = 1'b1;
        sb.push_back(model(v, cyc + 1));
        tick(1);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < BIN_W + 6) begin
            tick(1);
            n++;
        end
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL %s_timeout: pending=%0d expected 0", tag, sb.size());
        end
        tick(1);
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        tick(2);
        rst = 1'b0;
        check_bit("reset_busy", busy, 1'b0);

        // 1: zero
        kick('0);
        drain("t1");

        // 2: busy for exactly BIN_W cycles, then done
        kick(26'd12345678);
        for (int i = 0; i < BIN_W; i++) begin
            check_bit("busy_during", busy, 1'b1);
            tick(1);
        end
        check_bit("busy_after", busy, 1'b0);
        check_bit("done_after", done, 1'b1);
        drain("t2");

        // 3: full scale, then small value
        kick(26'h3FFFFFF);
        drain("t3a");
        kick(26'd9);
        drain("t3b");

        // 4: start while busy ignored; start held through done accepted at once
        kick(26'd100);
        tick(5);
        bin   = 26'd555;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        bin   = 26'd321;
        start = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < BIN_W + 4) begin
            tick(1);
            n++;
        end
        check_bit("b2b_idle", busy, 1'b0);
        check_bit("b2b_done", done, 1'b1);
        sb.push_back(model(26'd321, cyc + 1));
        tick(1);
        start = 1'b0;
        check_bit("b2b_busy", busy, 1'b1);
        drain("t4");

        // 5: reset mid-conversion aborts; rst beats start
        bin   = 26'd999;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        tick(BIN_W + 3);
        rst   = 1'b1;
        start = 1'b1;
        bin   = 26'd5;
        tick(1);
        rst   = 1'b0;
        start = 1'b0;
        check_bit("rst_start_busy", busy, 1'b0);
        tick(3);
        check_bit("rst_start_idle", busy, 1'b0);

`ifdef BIN2BCD_SIGN_EN
        // 6: signed inputs
        kick('1);
        drain("t6a");
        kick(26'h2000000);
        drain("t6b");
        kick(26'd42);
        drain("t6c");
`endif

        kick(26'd67108863);
        drain("tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
